// File: rtl/regfile_sb_if.sv
// Register file bus: read ports, write-back port,
// issue tracking and scoreboard status.
interface regfile_sb_if;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic        busy1;
  logic        busy2;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        issue_valid;
  logic        issue_we;
  logic [4:0]  issue_dest;
  logic        flush;
  logic        sb_overflow;
  logic        sb_underflow;

  modport master (
    output raddr1, raddr2,
    output rf_wen, rf_waddr, rf_wdata,
    output issue_valid, issue_we, issue_dest,
    output flush,
    input  rdata1, rdata2, busy1, busy2,
    input  sb_overflow, sb_underflow
  );

  modport slave (
    input  raddr1, raddr2,
    input  rf_wen, rf_waddr, rf_wdata,
    input  issue_valid, issue_we, issue_dest,
    input  flush,
    output rdata1, rdata2, busy1, busy2,
    output sb_overflow, sb_underflow
  );
endinterface

// File: rtl/regfile_sb.sv
// 32x32 register file with write-back bypass and
// per-register in-flight write counters.
module regfile_sb #(
  parameter int CNT_W = 2
) (
  input logic        clk,
  input logic        rst,
  regfile_sb_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [31:0]      regs   [32];
  logic [CNT_W-1:0] cnt    [32];
  logic [CNT_W-1:0] cnt_nx [32];
  logic [31:0]      inc;
  logic [31:0]      dec;
  logic             ovf_hit;
  logic             unf_hit;
  logic             ovf;
  logic             unf;
  logic             byp1;
  logic             byp2;
  logic             wr;

  assign wr = bus.rf_wen && (bus.rf_waddr != 5'd0);

  always_comb begin
    inc     = '0;
    dec     = '0;
    ovf_hit = 1'b0;
    unf_hit = 1'b0;
    for (int i = 1; i < 32; i++) begin
      inc[i] = bus.issue_valid & bus.issue_we
             & (bus.issue_dest == 5'(i));
      dec[i] = bus.rf_wen & (bus.rf_waddr == 5'(i));
    end
    for (int i = 0; i < 32; i++) begin
      cnt_nx[i] = cnt[i];
      if (bus.flush) begin
        cnt_nx[i] = '0;
      end else if (inc[i] && !dec[i]) begin
        if (cnt[i] == CNT_MAX) ovf_hit = 1'b1;
        else cnt_nx[i] = cnt[i] + CNT_W'(1);
      end else if (dec[i] && !inc[i]) begin
        if (cnt[i] == '0) unf_hit = 1'b1;
        else cnt_nx[i] = cnt[i] - CNT_W'(1);
      end
    end
  end

  // regs[0] and cnt[0] are only ever loaded with zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
        cnt[i]  <= '0;
      end
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (wr) regs[bus.rf_waddr] <= bus.rf_wdata;
      for (int i = 0; i < 32; i++) begin
        cnt[i] <= cnt_nx[i];
      end
      ovf <= ovf | ovf_hit;
      unf <= unf | unf_hit;
    end
  end

  assign byp1 = wr && (bus.rf_waddr == bus.raddr1);
  assign byp2 = wr && (bus.rf_waddr == bus.raddr2);

  assign bus.rdata1 = rst  ? '0 :
                      byp1 ? bus.rf_wdata :
                             regs[bus.raddr1];
  assign bus.rdata2 = rst  ? '0 :
                      byp2 ? bus.rf_wdata :
                             regs[bus.raddr2];

  // a write completing this cycle cancels one count
  assign bus.busy1 = !rst && (bus.raddr1 != 5'd0)
    && (cnt[bus.raddr1] > CNT_W'(dec[bus.raddr1]));
  assign bus.busy2 = !rst && (bus.raddr2 != 5'd0)
    && (cnt[bus.raddr2] > CNT_W'(dec[bus.raddr2]));

  assign bus.sb_overflow  = ovf;
  assign bus.sb_underflow = unf;

endmodule
